// File: rtl/stream_tag_demux.sv
`default_nettype none
// ============================================================================
// Module      : stream_tag_demux
// Description : Routes a valid/ready word stream to channel a or b by tag bit
//               data[0], buffering each channel in its own FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_tag_demux #(
    parameter int D_WIDTH = 6,
    parameter int A_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data_a,
    output logic               down_valid_a,
    input  logic               down_ready_a,
    output logic [D_WIDTH-1:0] down_data_b,
    output logic               down_valid_b,
    input  logic               down_ready_b,
    output logic [A_WIDTH:0]   count_a,
    output logic [A_WIDTH:0]   count_b
);

    localparam int               c_DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] c_FULL  = {1'b1, {A_WIDTH{1'b0}}};

    logic                    w_sel;
    logic [1:0]              w_full;
    logic [1:0]              w_valid;
    logic [1:0]              w_push;
    logic [1:0]              w_pop;
    logic [1:0]              w_ready_dn;
    logic [1:0][D_WIDTH-1:0] w_head;
    logic [1:0][A_WIDTH:0]   w_count;

    // Readiness follows only the tag of the offered word, never up_valid,
    // and a full channel refuses even when it pops in the same cycle.
    assign w_sel      = up_data[0];
    assign up_ready   = rst & (w_sel ? ~w_full[1] : ~w_full[0]);
    assign w_push[0]  = up_valid & up_ready & ~w_sel;
    assign w_push[1]  = up_valid & up_ready & w_sel;
    assign w_ready_dn = {down_ready_b, down_ready_a};
    assign w_pop      = w_valid & w_ready_dn;

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_chan
            logic [D_WIDTH-1:0] r_mem [c_DEPTH];
            logic [A_WIDTH-1:0] r_wr_ptr;
            logic [A_WIDTH-1:0] r_rd_ptr;
            logic [A_WIDTH:0]   r_count;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[ch]) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_pop[ch])  r_rd_ptr <= r_rd_ptr + 1'b1;
                    case ({w_push[ch], w_pop[ch]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            // Storage is deliberately left out of reset; valid masks stale data.
            always_ff @(posedge clk) begin
                if (w_push[ch]) r_mem[r_wr_ptr] <= up_data;
            end

            assign w_full[ch]  = (r_count == c_FULL);
            assign w_valid[ch] = (r_count != '0);
            assign w_head[ch]  = r_mem[r_rd_ptr];
            assign w_count[ch] = r_count;
        end
    endgenerate

    assign down_data_a  = w_head[0];
    assign down_valid_a = w_valid[0];
    assign count_a      = w_count[0];
    assign down_data_b  = w_head[1];
    assign down_valid_b = w_valid[1];
    assign count_b      = w_count[1];

endmodule
`default_nettype wire

// File: tb/tb_stream_tag_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_tag_demux
// Description : Directed self-checking bench for stream_tag_demux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_tag_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] up_data;
    logic       up_valid;
    logic       up_ready;
    logic [5:0] down_data_a;
    logic       down_valid_a;
    logic       down_ready_a;
    logic [5:0] down_data_b;
    logic       down_valid_b;
    logic       down_ready_b;
    logic [2:0] count_a;
    logic [2:0] count_b;

    int n_cmp = 0;
    int n_err = 0;

    stream_tag_demux #(.D_WIDTH(6), .A_WIDTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_data      (up_data),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .down_data_a  (down_data_a),
        .down_valid_a (down_valid_a),
        .down_ready_a (down_ready_a),
        .down_data_b  (down_data_b),
        .down_valid_b (down_valid_b),
        .down_ready_b (down_ready_b),
        .count_a      (count_a),
        .count_b      (count_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants sampled mid-cycle while out of reset.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("inv_count_a_max", 32'(count_a <= 3'd4), 32'd1);
            check("inv_count_b_max", 32'(count_b <= 3'd4), 32'd1);
            check("inv_valid_a", 32'(down_valid_a), 32'(count_a != 3'd0));
            check("inv_valid_b", 32'(down_valid_b), 32'(count_b != 3'd0));
            check("inv_push_full_a",
                  32'(up_valid && up_ready && !up_data[0] && count_a == 3'd4), 32'd0);
            check("inv_push_full_b",
                  32'(up_valid && up_ready && up_data[0] && count_b == 3'd4), 32'd0);
        end
    end

    initial begin
        int wi;
        int ri;
        int t;
        logic acc;

        rst          = 1'b0;
        up_data      = 6'h00;
        up_valid     = 1'b0;
        down_ready_a = 1'b0;
        down_ready_b = 1'b0;

        // Reset then idle
        repeat (3) tick();
        check("rst_up_ready_tag0", 32'(up_ready), 32'd0);
        up_data = 6'h01;
        #1;
        check("rst_up_ready_tag1", 32'(up_ready), 32'd0);
        check("rst_valid_a", 32'(down_valid_a), 32'd0);
        check("rst_valid_b", 32'(down_valid_b), 32'd0);
        check("rst_count_a", 32'(count_a), 32'd0);
        check("rst_count_b", 32'(count_b), 32'd0);
        rst = 1'b1;
        #1;
        check("post_rst_up_ready", 32'(up_ready), 32'd1);

        // Single route
        tick();
        down_ready_a = 1'b1;
        down_ready_b = 1'b1;
        up_data  = 6'h04;
        up_valid = 1'b1;
        #1;
        check("no_bypass_valid_a", 32'(down_valid_a), 32'd0);
        tick();
        check("route_a_valid", 32'(down_valid_a), 32'd1);
        check("route_a_data", 32'(down_data_a), 32'h04);
        check("route_a_count", 32'(count_a), 32'd1);
        up_data = 6'h07;
        tick();
        check("route_a_popped", 32'(count_a), 32'd0);
        check("route_b_valid", 32'(down_valid_b), 32'd1);
        check("route_b_data", 32'(down_data_b), 32'h07);
        up_valid = 1'b0;
        tick();
        check("route_b_popped", 32'(count_b), 32'd0);

        // Fill channel a
        down_ready_a = 1'b0;
        down_ready_b = 1'b0;
        up_valid = 1'b1;
        up_data = 6'h02; tick();
        up_data = 6'h06; tick();
        up_data = 6'h0A; tick();
        up_data = 6'h0E; tick();
        check("fill_count_a", 32'(count_a), 32'd4);
        check("fill_head_a", 32'(down_data_a), 32'h02);
        up_data = 6'h12;
        #1;
        check("full_refuse", 32'(up_ready), 32'd0);
        tick();
        check("full_hold_count", 32'(count_a), 32'd4);
        down_ready_a = 1'b1;
        #1;
        check("full_no_passthru", 32'(up_ready), 32'd0);
        tick();
        check("after_pop_count", 32'(count_a), 32'd3);
        check("after_pop_head", 32'(down_data_a), 32'h06);
        down_ready_a = 1'b0;
        #1;
        check("after_pop_ready", 32'(up_ready), 32'd1);
        tick();
        up_valid = 1'b0;
        check("refill_count_a", 32'(count_a), 32'd4);

        // Head-of-line independence: a full and stalled, b keeps flowing
        down_ready_b = 1'b1;
        up_valid = 1'b1;
        up_data = 6'h03;
        #1;
        check("hol_ready_b", 32'(up_ready), 32'd1);
        tick();
        check("hol_b0", 32'(down_data_b), 32'h03);
        up_data = 6'h05; tick();
        check("hol_b1", 32'(down_data_b), 32'h05);
        check("hol_b1_count", 32'(count_b), 32'd1);
        up_data = 6'h09; tick();
        check("hol_b2", 32'(down_data_b), 32'h09);
        up_valid = 1'b0;
        tick();
        check("hol_b_empty", 32'(count_b), 32'd0);
        check("hol_a_stuck", 32'(count_a), 32'd4);

        // Drain a in order
        down_ready_a = 1'b1;
        check("drain_a0", 32'(down_data_a), 32'h06); tick();
        check("drain_a1", 32'(down_data_a), 32'h0A); tick();
        check("drain_a2", 32'(down_data_a), 32'h0E); tick();
        check("drain_a3", 32'(down_data_a), 32'h12); tick();
        check("drain_a_empty", 32'(count_a), 32'd0);

        // Wrap with concurrent push/pop, consumer ready every other cycle
        wi = 0;
        ri = 0;
        t  = 0;
        while (ri < 10 && t < 80) begin
            up_valid     = (wi < 10);
            up_data      = 6'(wi * 2);
            down_ready_a = (t % 2 == 0);
            #1;
            if (down_valid_a && down_ready_a) begin
                check("wrap_order", 32'(down_data_a), 32'(ri * 2));
                ri++;
            end
            acc = up_valid && up_ready;
            tick();
            if (acc) wi++;
            t++;
        end
        up_valid = 1'b0;
        check("wrap_all_out", 32'(ri), 32'd10);
        check("wrap_all_in", 32'(wi), 32'd10);
        check("wrap_empty", 32'(count_a), 32'd0);

        // Reset mid-stream
        down_ready_a = 1'b0;
        down_ready_b = 1'b0;
        up_valid = 1'b1;
        up_data = 6'h10; tick();
        up_data = 6'h11; tick();
        up_data = 6'h14; tick();
        up_data = 6'h13; tick();
        up_data = 6'h18; tick();
        up_valid = 1'b0;
        check("mid_count_a", 32'(count_a), 32'd3);
        check("mid_count_b", 32'(count_b), 32'd2);
        rst = 1'b0;
        #1;
        check("mid_rst_valid_a", 32'(down_valid_a), 32'd0);
        check("mid_rst_valid_b", 32'(down_valid_b), 32'd0);
        check("mid_rst_count_a", 32'(count_a), 32'd0);
        check("mid_rst_count_b", 32'(count_b), 32'd0);
        check("mid_rst_ready", 32'(up_ready), 32'd0);
        tick();
        rst = 1'b1;
        down_ready_a = 1'b1;
        up_data  = 6'h08;
        up_valid = 1'b1;
        tick();
        up_valid = 1'b0;
        check("post_mid_valid_a", 32'(down_valid_a), 32'd1);
        check("post_mid_data_a", 32'(down_data_a), 32'h08);
        check("post_mid_count_a", 32'(count_a), 32'd1);
        check("post_mid_valid_b", 32'(down_valid_b), 32'd0);
        tick();
        check("post_mid_drained", 32'(count_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
